// File: rtl/cla3_slice_sequencer.sv
// cla3_slice_sequencer
// Multi-cycle WIDTH-bit adder controller for a 3-bit carry-lookahead adder.
// It registers two operands and a carry-in. It then presents one 3-bit slice at a
// time to the external adder, starting with the LSB slice. Each slice is held for
// SETTLE clocks before the sum and carry-out are captured. The captured carry-out
// becomes the carry-in of the next slice.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous reset, active high
//   start_i      request; sampled only while idle
//   a_i, b_i     operands, sampled with start_i
//   cin_i        carry-in, sampled with start_i
//   busy_o       high while slices are being processed
//   done_o       one-cycle pulse; result_o/cout_o are valid
//   result_o     registered sum; held until the next accepted start
//   cout_o       registered final carry-out; held like result_o
//   add_x_o      adder x input (current slice of operand A)
//   add_y_o      adder y input (current slice of operand B)
//   add_cin_o    adder carry-in (running carry register)
//   add_sum_i    adder sum
//   add_cout_i   adder carry-out
//   state_o      FSM state (debug visibility)
//
// Handshake: start_i is a single-cycle request. It is accepted only in IDLE, and it
// is neither queued nor acknowledged while busy_o or done_o is high. done_o is
// asserted for exactly one cycle per accepted request.
module cla3_slice_sequencer #(
    parameter int WIDTH  = 12,
    parameter int SETTLE = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic [2:0]       add_x_o,
    output logic [2:0]       add_y_o,
    output logic             add_cin_o,
    input  logic [2:0]       add_sum_i,
    input  logic             add_cout_i,
    output logic [1:0]       state_o
);

    localparam int N     = WIDTH / 3;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    if ((WIDTH % 3) != 0 || WIDTH < 3) begin : g_bad_width
        $error("WIDTH must be a positive multiple of 3");
    end
    if (SETTLE < 1) begin : g_bad_settle
        $error("SETTLE must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d      = a_i;
                    b_d      = b_i;
                    carry_d  = cin_i;
                    idx_d    = '0;
                    cnt_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    // Capture edge: the adder inputs have now been stable for SETTLE cycles.
                    result_d[3*idx_q +: 3] = add_sum_i;
                    carry_d                = add_cout_i;
                    cnt_d                  = '0;
                    if (idx_q == IDX_LAST) begin
                        cout_d  = add_cout_i;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every output comes from a register, so no input reaches an output combinationally.
    assign busy_o    = (state_q == RUN);
    assign done_o    = (state_q == DONE);
    assign result_o  = result_q;
    assign cout_o    = cout_q;
    assign add_x_o   = a_q[3*idx_q +: 3];
    assign add_y_o   = b_q[3*idx_q +: 3];
    assign add_cin_o = carry_q;
    assign state_o   = state_q;

endmodule
